// File: rtl/cymometer_pkg.sv
// Shared types and helpers for the multi-channel reciprocal frequency meter.
package cymometer_pkg;

  typedef enum logic [1:0] {
    ChIdle = 2'd0,
    ChArm  = 2'd1,
    ChMeas = 2'd2
  } chan_state_e;

  localparam int unsigned DefaultCntW = 32;

  // LSB of channel idx inside a packed per-channel output bus.
  function automatic int slice_lsb(int idx, int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cymometer_chan.sv
// One measurement channel: fx synchroniser, edge detect, gate-aligned FSM,
// saturating fs/fx counters and sticky result registers.
module cymometer_chan
  import cymometer_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             i_sys_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_gstart,
  input  logic             i_sgate,
  input  logic             i_clk_fx,
  input  logic             i_rd_ack,
  output logic [CNT_W-1:0] o_fs_cnt,
  output logic [CNT_W-1:0] o_fx_cnt,
  output logic             o_res_valid,
  output logic             o_res_timeout,
  output logic             o_res_ovf,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [2:0]       r_sync;
  logic             w_edge;
  chan_state_e      r_state, w_state_next;
  logic [CNT_W-1:0] r_fs, r_fx, w_fs_next, w_fx_next;
  logic             r_sat, w_sat_next;
  logic             w_latch, w_timeout;
  logic [CNT_W-1:0] w_fs_close, w_fx_close;
  logic             w_ovf_close;
  logic [CNT_W-1:0] r_fs_res, r_fx_res;
  logic             r_valid, r_timeout, r_ovf;

  // Two synchroniser stages plus one history stage for the rising-edge detect.
  assign w_edge = r_sync[1] & ~r_sync[2];

  // The closing edge's own period is included, saturating at CntMax.
  assign w_fs_close  = (r_fs == CntMax) ? CntMax : r_fs + 1'b1;
  assign w_fx_close  = (r_fx == CntMax) ? CntMax : r_fx + 1'b1;
  assign w_ovf_close = r_sat | (r_fs == CntMax) | (r_fx == CntMax);

  always_comb begin
    w_state_next = r_state;
    w_fs_next    = r_fs;
    w_fx_next    = r_fx;
    w_sat_next   = r_sat;
    w_latch      = 1'b0;
    w_timeout    = 1'b0;
    if (!i_en) begin
      w_state_next = ChIdle;
    end else begin
      unique case (r_state)
        ChIdle: begin
          if (i_gstart) w_state_next = ChArm;
        end
        ChArm: begin
          if (i_gstart) begin
            w_timeout = 1'b1;
          end else if (w_edge) begin
            w_state_next = ChMeas;
            w_fs_next    = '0;
            w_fx_next    = '0;
            w_sat_next   = 1'b0;
          end
        end
        ChMeas: begin
          if (i_gstart) begin
            w_timeout    = 1'b1;
            w_state_next = ChArm;
          end else if (w_edge && !i_sgate) begin
            w_latch      = 1'b1;
            w_state_next = ChIdle;
          end else begin
            w_fs_next  = (r_fs == CntMax) ? r_fs : r_fs + 1'b1;
            w_sat_next = r_sat | (r_fs == CntMax);
            if (w_edge) begin
              w_fx_next = (r_fx == CntMax) ? r_fx : r_fx + 1'b1;
              if (r_fx == CntMax) w_sat_next = 1'b1;
            end
          end
        end
        default: w_state_next = ChIdle;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_state <= ChIdle;
      r_fs    <= '0;
      r_fx    <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[1:0], i_clk_fx};
      r_state <= w_state_next;
      r_fs    <= w_fs_next;
      r_fx    <= w_fx_next;
      r_sat   <= w_sat_next;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fs_res  <= '0;
      r_fx_res  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_latch) begin
        r_fs_res  <= w_fs_close;
        r_fx_res  <= w_fx_close;
        r_timeout <= 1'b0;
        r_ovf     <= w_ovf_close;
      end else if (w_timeout) begin
        r_fs_res  <= '0;
        r_fx_res  <= '0;
        r_timeout <= 1'b1;
        r_ovf     <= 1'b0;
      end
      // A new result beats a coincident acknowledge.
      if (w_latch || w_timeout) r_valid <= 1'b1;
      else if (i_rd_ack)        r_valid <= 1'b0;
    end
  end

  assign o_fs_cnt      = r_fs_res;
  assign o_fx_cnt      = r_fx_res;
  assign o_res_valid   = r_valid;
  assign o_res_timeout = r_timeout;
  assign o_res_ovf     = r_ovf;
  assign o_busy        = (r_state != ChIdle);

endmodule

// File: rtl/cymometer_mc.sv
// Multi-channel reciprocal frequency meter: shared soft gate driving CH
// independent measurement channels.
module cymometer_mc
  import cymometer_pkg::*;
#(
  parameter int unsigned CH       = 4,
  parameter int unsigned CNT_W    = DefaultCntW,
  parameter int unsigned GATE_CYC = 50_000_000,
  parameter int unsigned GAP_CYC  = 1_000
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [CH-1:0]         i_clk_fx,
  input  logic [CH-1:0]         i_rd_ack,
  output logic [CH*CNT_W-1:0]   o_fs_cnt_out,
  output logic [CH*CNT_W-1:0]   o_fx_cnt_out,
  output logic [CH-1:0]         o_res_valid,
  output logic [CH-1:0]         o_res_timeout,
  output logic [CH-1:0]         o_res_ovf,
  output logic [CH-1:0]         o_busy
);

  localparam int unsigned FrameCyc = GATE_CYC + GAP_CYC;
  localparam int unsigned GcntW    = $clog2(FrameCyc);
  localparam logic [GcntW-1:0] GcntLast = GcntW'(FrameCyc - 1);
  localparam logic [GcntW-1:0] GateEnd  = GcntW'(GATE_CYC);

  logic [GcntW-1:0] r_gcnt;
  logic             w_sgate;
  logic             w_gstart;

  assign w_sgate  = (r_gcnt < GateEnd);
  assign w_gstart = i_en && (r_gcnt == '0);

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_gcnt <= '0;
    else if (!i_en)              r_gcnt <= '0;
    else if (r_gcnt == GcntLast) r_gcnt <= '0;
    else                         r_gcnt <= r_gcnt + 1'b1;
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    localparam int Lsb = slice_lsb(gi, CNT_W);
    cymometer_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .i_sys_clk     (i_sys_clk),
      .i_rst_n       (i_rst_n),
      .i_en          (i_en),
      .i_gstart      (w_gstart),
      .i_sgate       (w_sgate),
      .i_clk_fx      (i_clk_fx[gi]),
      .i_rd_ack      (i_rd_ack[gi]),
      .o_fs_cnt      (o_fs_cnt_out[Lsb +: CNT_W]),
      .o_fx_cnt      (o_fx_cnt_out[Lsb +: CNT_W]),
      .o_res_valid   (o_res_valid[gi]),
      .o_res_timeout (o_res_timeout[gi]),
      .o_res_ovf     (o_res_ovf[gi]),
      .o_busy        (o_busy[gi])
    );
  end

endmodule

// File: tb/tb_cymometer_mc.sv
// Bench for cymometer_mc: timestamp-based reference model compared every cycle,
// plus directed literal expectations for the key scenarios.
module tb_cymometer_mc;

  localparam int GATE = 100;
  localparam int GAP  = 20;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [1:0]  fx_a = '0, ack_a = '0;
  logic        fx_b = 1'b0, ack_b = 1'b0;
  logic [63:0] fs_a, fxc_a;
  logic [1:0]  val_a, to_a, ovf_a, busy_a;
  logic [5:0]  fs_b, fxc_b;
  logic        val_b, to_b, ovf_b, busy_b;

  int n_checks = 0, n_err = 0, tcount = 0;

  // Virtual channels: 0,1 = wide DUT ch0/ch1, 2 = 6-bit DUT ch0.
  bit     act[3] = '{1'b1, 1'b1, 1'b1};
  int     per[3] = '{10, 7, 10};
  int     off[3] = '{3, 5, 3};
  longint maxv[3] = '{64'd4294967295, 64'd4294967295, 64'd63};

  int       m_st[3], m_topen[3], m_ned[3], m_gcnt, m_tick;
  longint   m_fs[3], m_fx[3];
  bit       m_val[3], m_to[3], m_ovf[3];
  bit [2:0] m_hist[3];

  cymometer_mc #(.CH(2), .CNT_W(32), .GATE_CYC(GATE), .GAP_CYC(GAP)) u_dut_a (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clk_fx(fx_a), .i_rd_ack(ack_a),
    .o_fs_cnt_out(fs_a), .o_fx_cnt_out(fxc_a), .o_res_valid(val_a),
    .o_res_timeout(to_a), .o_res_ovf(ovf_a), .o_busy(busy_a)
  );

  cymometer_mc #(.CH(1), .CNT_W(6), .GATE_CYC(GATE), .GAP_CYC(GAP)) u_dut_b (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clk_fx(fx_b), .i_rd_ack(ack_b),
    .o_fs_cnt_out(fs_b), .o_fx_cnt_out(fxc_b), .o_res_valid(val_b),
    .o_res_timeout(to_b), .o_res_ovf(ovf_b), .o_busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int ch, longint got, longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s ch%0d @%0d: got %0d, expected %0d", name, ch, tcount, got, exp);
    end
  endtask

  function automatic logic pad_val(int v, int n);
    int ph;
    if (!act[v]) return 1'b0;
    ph = ((n - off[v]) % per[v] + per[v]) % per[v];
    return ph < per[v] / 2;
  endfunction

  // Pads change 1 time unit after each rising edge; tcount names the interval.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tcount++;
      fx_a = {pad_val(1, tcount), pad_val(0, tcount)};
      fx_b = pad_val(2, tcount);
    end
  end

  task automatic model_reset();
    m_gcnt = 0;
    for (int v = 0; v < 3; v++) begin
      m_st[v] = 0; m_topen[v] = 0; m_ned[v] = 0; m_fs[v] = 0; m_fx[v] = 0;
      m_val[v] = 0; m_to[v] = 0; m_ovf[v] = 0; m_hist[v] = '0;
    end
  endtask

  // Results from timestamps: fs = closing tick - opening tick, fx = edges spanned.
  task automatic model_step();
    bit gst, sg, edg, padv, ackv, lat;
    longint t, f;
    gst = en && (m_gcnt == 0);
    sg  = (m_gcnt < GATE);
    for (int v = 0; v < 3; v++) begin
      if (v < 2) begin padv = fx_a[v]; ackv = ack_a[v]; end
      else begin padv = fx_b; ackv = ack_b; end
      // Pad edge reaches the channel logic three clocks after it is driven.
      edg = m_hist[v][1] && !m_hist[v][2];
      lat = 0;
      if (!en) m_st[v] = 0;
      else if (m_st[v] == 0) begin
        if (gst) m_st[v] = 1;
      end else if (gst) begin
        m_fs[v] = 0; m_fx[v] = 0; m_to[v] = 1; m_ovf[v] = 0; lat = 1; m_st[v] = 1;
      end else if (m_st[v] == 1) begin
        if (edg) begin m_st[v] = 2; m_topen[v] = m_tick; m_ned[v] = 0; end
      end else if (edg && !sg) begin
        t = longint'(m_tick - m_topen[v]);
        f = longint'(m_ned[v] + 1);
        m_fs[v]  = (t > maxv[v]) ? maxv[v] : t;
        m_fx[v]  = (f > maxv[v]) ? maxv[v] : f;
        m_ovf[v] = (t > maxv[v]) || (f > maxv[v]);
        m_to[v]  = 0; lat = 1; m_st[v] = 0;
      end else if (edg) begin
        m_ned[v]++;
      end
      if (lat) m_val[v] = 1;
      else if (ackv) m_val[v] = 0;
      m_hist[v] = {m_hist[v][1:0], padv};
    end
    m_gcnt = !en ? 0 : ((m_gcnt == GATE + GAP - 1) ? 0 : m_gcnt + 1);
    m_tick++;
  endtask

  initial begin
    model_reset();
    m_tick = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    longint dfs, dfx;
    bit dv, dt, dov, db;
    forever begin
      @(negedge clk);
      if (tcount >= 1) begin
        for (int v = 0; v < 3; v++) begin
          if (v < 2) begin
            dfs = longint'(fs_a[v*32 +: 32]); dfx = longint'(fxc_a[v*32 +: 32]);
            dv = val_a[v]; dt = to_a[v]; dov = ovf_a[v]; db = busy_a[v];
          end else begin
            dfs = longint'(fs_b); dfx = longint'(fxc_b);
            dv = val_b; dt = to_b; dov = ovf_b; db = busy_b;
          end
          check("model fs_cnt", v, dfs, m_fs[v]);
          check("model fx_cnt", v, dfx, m_fx[v]);
          check("model res_valid", v, longint'(dv), longint'(m_val[v]));
          check("model res_timeout", v, longint'(dt), longint'(m_to[v]));
          check("model res_ovf", v, longint'(dov), longint'(m_ovf[v]));
          check("model busy", v, longint'(db), longint'(m_st[v] != 0));
        end
      end
    end
  end

  task automatic wait_until(int n);
    while (tcount < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_valid(int v, int budget);
    int i = 0;
    while (!val_a[v] && i < budget) begin
      @(posedge clk);
      #2;
      i++;
    end
    n_checks++;
    if (!val_a[v]) begin
      n_err++;
      $display("FAIL wait_valid ch%0d: got res_valid=0 after %0d cycles, expected 1", v, budget);
    end
  endtask

  initial begin
    wait_until(2);
    check("reset fs_cnt", 0, longint'(fs_a[31:0]), 0);
    check("reset valid", 0, longint'(val_a), 0);
    check("reset busy", 0, longint'(busy_a), 0);
    wait_until(3);
    rst_n = 1'b1;
    wait_until(20);
    en = 1'b1;

    // Period 10 and period 7 over a 100-cycle gate; 6-bit instance saturates fs.
    wait_valid(0, 200);
    check("ch0 latch tick", 0, longint'(tcount), 126);
    check("ch0 fs", 0, longint'(fs_a[31:0]), 100);
    check("ch0 fx", 0, longint'(fxc_a[31:0]), 10);
    check("ch0 timeout", 0, longint'(to_a[0]), 0);
    check("ch0 ovf", 0, longint'(ovf_a[0]), 0);
    check("sat fs", 2, longint'(fs_b), 63);
    check("sat fx", 2, longint'(fxc_b), 10);
    check("sat ovf", 2, longint'(ovf_b), 1);
    wait_valid(1, 20);
    check("ch1 latch tick", 1, longint'(tcount), 127);
    check("ch1 fs", 1, longint'(fs_a[63:32]), 105);
    check("ch1 fx", 1, longint'(fxc_a[63:32]), 15);

    // Plain acknowledge, then acknowledge coincident with the next latch.
    wait_until(130); ack_a[0] = 1'b1;
    wait_until(131); ack_a[0] = 1'b0;
    check("ack clears valid", 0, longint'(val_a[0]), 0);
    wait_until(245); ack_a[0] = 1'b1;
    wait_until(246); ack_a[0] = 1'b0;
    check("latch beats ack", 0, longint'(val_a[0]), 1);
    check("latch beats ack fs", 0, longint'(fs_a[31:0]), 100);

    // Dead input on ch0 across a whole frame.
    wait_until(250); act[0] = 1'b0;
    wait_until(300); ack_a[0] = 1'b1;
    wait_until(301); ack_a[0] = 1'b0;
    wait_until(380);
    check("dead pre valid", 0, longint'(val_a[0]), 0);
    wait_until(381);
    check("timeout flag", 0, longint'(to_a[0]), 1);
    check("timeout valid", 0, longint'(val_a[0]), 1);
    check("timeout fs", 0, longint'(fs_a[31:0]), 0);
    check("timeout busy", 0, longint'(busy_a[0]), 1);
    wait_until(388); act[0] = 1'b1;
    wait_until(486);
    check("late open fs", 0, longint'(fs_a[31:0]), 90);
    check("late open fx", 0, longint'(fxc_a[31:0]), 9);

    // Drop en while ch0 is measuring.
    wait_until(550); en = 1'b0;
    wait_until(551);
    check("en drop busy", 0, longint'(busy_a[0]), 0);
    check("en drop fs hold", 0, longint'(fs_a[31:0]), 90);
    check("en drop fx hold", 0, longint'(fxc_a[31:0]), 9);
    wait_until(700); en = 1'b1;

    // Asynchronous reset in the middle of a measurement.
    wait_until(760);
    check("pre reset busy", 0, longint'(busy_a[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst fs", 0, longint'(fs_a), 0);
    check("async rst valid", 0, longint'({val_a, to_a, ovf_a, busy_a}), 0);
    check("async rst b", 2, longint'({fs_b, val_b, ovf_b, busy_b}), 0);
    wait_until(765); rst_n = 1'b1;

    wait_until(900);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cymometer_mc.md
Name: cymometer_mc

Overview:
- Multi-channel equal-precision (reciprocal) frequency meter core, successor to the single-channel fs/fx counter pair.
- Measures CH independent fx inputs against one high-speed reference sys_clk (PLL output), using one shared soft gate.
- Per-channel results carry a sticky valid/ack handshake, plus timeout and overflow flags.
- Sits between the PLL and the SPI readout block; SPI reads packed results and pulses rd_ack.

Parameters:
- CH, 4, number of measured channels (1..16).
- CNT_W, 32, width of each fs/fx result counter.
- GATE_CYC, 50_000_000, soft-gate high time in sys_clk cycles (≥ 4).
- GAP_CYC, 1_000, soft-gate low time in sys_clk cycles (≥ 2).

Ports:
- sys_clk  in  1  reference clock fs; sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  measurement enable; low holds gate counter at 0 and all channels in IDLE.
- clk_fx  in  CH  asynchronous measured signals; must satisfy f_fx < f_sys/4.
- rd_ack  in  CH  one-cycle pulse per channel; clears that channel's res_valid.
- fs_cnt_out  out  CH*CNT_W  per-channel reference-cycle count; channel i at [i*CNT_W +: CNT_W].
- fx_cnt_out  out  CH*CNT_W  per-channel measured-period count, same packing.
- res_valid  out  CH  sticky: result updated and not yet acknowledged.
- res_timeout  out  CH  last result ended by timeout (counts are 0).
- res_ovf  out  CH  last result had a saturated counter.
- busy  out  CH  channel is in ARM or MEAS.

Behaviour:
- Reset (rst_n low, async): all outputs are 0, the gate counter is 0, and all channels are in IDLE.
- Input conditioning: each clk_fx bit passes through a 2-FF synchroniser and a rising-edge detector. The edge pulse is 1 cycle, 3 cycles after the pad edge; this fixed offset does not affect the counts.
- Soft gate:
  - gcnt cycles through 0..GATE_CYC+GAP_CYC-1 while en=1.
  - sgate = (gcnt < GATE_CYC).
  - gstart pulses when gcnt==0 and en=1.
  - en=0 resets gcnt to 0 synchronously.
- Channel FSM (IDLE, ARM, MEAS):
  - IDLE: on gstart → ARM.
  - ARM: on fx edge → MEAS; clear fs=0 and fx=0.
  - MEAS: each cycle fs+=1; each fx edge fx+=1.
  - MEAS close: an fx edge while sgate=0 closes the measurement. Latch fs+1 and fx+1 into the outputs, set res_valid, clear res_timeout, set res_ovf from the saturation flag, → IDLE.
  - Result definition: fs = sys_clk periods between opening and closing edges; fx = fx periods in that window. f_fx = f_sys·fx/fs (computed downstream).
  - Timeout: gstart while in ARM or MEAS latches fs=fx=0, sets res_timeout and res_valid, and stays in/enters ARM for the new gate.
  - en=0 in any state: → IDLE, no result latched, outputs unchanged.
- Saturation: fs and fx stop at 2^CNT_W−1. A sticky per-measurement sat flag is set, and is cleared on ARM→MEAS.
- Handshake:
  - res_valid is set on latch and cleared by rd_ack.
  - Latch and rd_ack in the same cycle: latch wins, res_valid=1.
  - Output count registers change only on latch; they hold otherwise, regardless of ack.
- Channels are fully independent, except for the shared gcnt/sgate/gstart.

Decomposition:
- Package cymometer_pkg holds:
  - the channel state encoding (IDLE/ARM/MEAS);
  - the default CNT_W;
  - a slice helper for the packed output index.
- One sub-module, cymometer_chan: synchroniser, edge detect, FSM, saturating counters and result registers for one channel.
- Top level: gate counter plus a generate loop of CH instances.

Test Plan:
- Periodic input, no timeout:
  - Stimulus: CH=2, GATE_CYC=100, GAP_CYC=20; ch0 fx period 10 cycles, no edge coincident with the sgate fall.
  - Response: fs_cnt[0]=100, fx_cnt[0]=10, res_valid[0]=1, timeout=0, ovf=0.
- Non-integer ratio:
  - Stimulus: ch1 fx period 7 cycles, same gate.
  - Response: fx_cnt[1]=15, fs_cnt[1]=105, ratio exact.
- Dead input:
  - Stimulus: ch0 clk_fx held low for a full gate period.
  - Response: at the next gstart, fs=fx=0, res_timeout[0]=1, res_valid[0]=1; busy[0] stays 1.
- Saturation:
  - Stimulus: CNT_W=6, GATE_CYC=100, fx period 10.
  - Response: fs_cnt=63, res_ovf=1; fx_cnt=10 (not saturated).
- Handshake:
  - Stimulus: rd_ack[0] pulsed after a result; then rd_ack pulsed in the same cycle as a new latch.
  - Response: first ack clears res_valid[0]; the coincident case leaves res_valid[0]=1 with the new counts.
- Mid-operation abort:
  - Stimulus: assert rst_n low mid-MEAS → all outputs are 0 immediately. Separately, drop en mid-MEAS.
  - Response: for en low, busy=0 next cycle, outputs hold, and no result is latched.
